systolic_ctrl_n: RTL and testbench

- Parametrised wavefront controller for an N x N upper-triangular Givens-rotation systolic array: N boundary cells on the diagonal, N(N-1)/2 internal cells above it.
- It is the N-generic successor of the fixed three-cell control. It adds a valid/ready row handshake, a runtime frame length, an accumulate mode, drain tracking and a done pulse.
- It sits beside the array and drives one 2-bit operation code per PE. Each code is skewed so that it meets the data wavefront.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/op_delay_line.sv | 29 ++
 rtl/systolic_ctrl_n.sv | 135 +++++++++++++
 tb/tb_systolic_ctrl_n.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic wavefront controller and the array generator:
// PE op codes, controller state encoding and the triangular PE index mapping.
package systolic_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_INIT   = 2'b01;
    localparam logic [1:0] OP_UPDATE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Row-major position of PE(i,j), 1-based, i <= j, in the upper triangle of an n x n array.
    function automatic int pe_index(input int i, input int j, input int n);
        return (i - 1) * n - ((i - 1) * (i - 2)) / 2 + (j - i);
    endfunction

endpackage

// File: rtl/op_delay_line.sv
// Shift register of 2-bit op codes; stage k holds the code that entered k cycles earlier.
// All stages clear to HOLD on reset so an aborted frame leaves nothing in flight.
module op_delay_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            code,
    output logic [DEPTH-1:0][1:0] stages
);

    logic [DEPTH-1:0][1:0] stage_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= {DEPTH{OP_HOLD}};
        end else begin
            stage_reg[0] <= code;
            for (int k = 1; k < DEPTH; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    assign stages = stage_reg;

endmodule

// File: rtl/systolic_ctrl_n.sv
// Wavefront controller for an N x N triangular Givens array: row handshake, frame
// sequencing and one skewed 2-bit op code per PE taken from a shared delay line.
module systolic_ctrl_n
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int ROW_W = 8,
    localparam int NPE  = N * (N + 1) / 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROW_W-1:0]   cfg_rows,
    input  logic               cfg_accum,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*NPE-1:0]   op,
    output logic [ROW_W-1:0]   row_idx,
    output logic               busy,
    output logic               done
);

    localparam int DEPTH = 2 * N - 1;
    localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   rows_reg, rows_next;
    logic [ROW_W-1:0]   row_idx_reg, row_idx_next;
    logic               accum_reg, accum_next;
    logic               first_reg, first_next;
    logic               in_ready_reg, in_ready_next;
    logic [CW-1:0]      drain_cnt_reg, drain_cnt_next;
    logic [1:0]         code;
    logic               accept;
    logic               last_row;
    logic [DEPTH-1:0][1:0] stages;

    assign accept   = in_valid & in_ready_reg;
    // Row count never wraps: the largest index compared here is cfg_rows-1.
    assign last_row = (row_idx_reg + ROW_W'(1)) == rows_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rows_reg      <= '0;
            row_idx_reg   <= '0;
            accum_reg     <= 1'b0;
            first_reg     <= 1'b0;
            in_ready_reg  <= 1'b0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rows_reg      <= rows_next;
            row_idx_reg   <= row_idx_next;
            accum_reg     <= accum_next;
            first_reg     <= first_next;
            in_ready_reg  <= in_ready_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rows_next      = rows_reg;
        row_idx_next   = row_idx_reg;
        accum_next     = accum_reg;
        first_next     = first_reg;
        drain_cnt_next = drain_cnt_reg;
        code           = OP_HOLD;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    rows_next      = cfg_rows;
                    accum_next     = cfg_accum;
                    first_next     = 1'b1;
                    row_idx_next   = '0;
                    drain_cnt_next = '0;
                    state_next     = (cfg_rows == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    code         = (first_reg && !accum_reg) ? OP_INIT : OP_UPDATE;
                    first_next   = 1'b0;
                    row_idx_next = row_idx_reg + ROW_W'(1);
                    if (last_row) begin
                        state_next     = DRAIN;
                        drain_cnt_next = '0;
                    end
                end
            end
            DRAIN: begin
                // Long enough for the last code to reach PE(N,N) at tap 2N-2.
                if (drain_cnt_reg == CW'(DEPTH - 1)) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        in_ready_next = (state_next == RUN);
    end

    op_delay_line #(
        .DEPTH (DEPTH)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .code   (code),
        .stages (stages)
    );

    genvar gi, gj;
    generate
        for (gi = 1; gi <= N; gi++) begin : g_row
            for (gj = 1; gj <= N; gj++) begin : g_col
                if (gj >= gi) begin : g_pe
                    localparam int P = pe_index(gi, gj, N);
                    assign op[2*P +: 2] = stages[gi + gj - 2];
                end
            end
        end
    endgenerate

    assign in_ready = in_ready_reg;
    assign row_idx  = row_idx_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_systolic_ctrl_n.sv
// Bench for systolic_ctrl_n: five instances (N = 1..5) share one stimulus stream and are
// checked every cycle against a frame-level model, plus literal expectations per scenario.
module tb_systolic_ctrl_n;
    import systolic_pkg::*;

    localparam int NI   = 5;
    localparam int MAXC = 8192;
    localparam int RC   = 300;

    logic       clk = 1'b0;
    logic       rst, start, cfg_accum, in_valid;
    logic [7:0] cfg_rows;

    logic [29:0] op_w   [NI];
    logic        rdy_w  [NI];
    logic        busy_w [NI];
    logic        done_w [NI];
    logic [7:0]  ridx_w [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int NN = gi + 1;
            logic [NN*(NN+1)-1:0] op_l;
            logic                 rdy_l, busy_l, done_l;
            logic [7:0]           ridx_l;
            systolic_ctrl_n #(.N(NN), .ROW_W(8)) dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start),
                .cfg_rows  (cfg_rows),
                .cfg_accum (cfg_accum),
                .in_valid  (in_valid),
                .in_ready  (rdy_l),
                .op        (op_l),
                .row_idx   (ridx_l),
                .busy      (busy_l),
                .done      (done_l)
            );
            assign op_w[gi]   = 30'(op_l);
            assign rdy_w[gi]  = rdy_l;
            assign busy_w[gi] = busy_l;
            assign done_w[gi] = done_l;
            assign ridx_w[gi] = ridx_l;
        end
    endgenerate

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: phase 0 idle, 1 accepting rows, 2 waiting for done at done_at.
    int         ph       [NI];
    int         cnt      [NI];
    int         mrows    [NI];
    int         done_at  [NI];
    int         rst_mark [NI];
    bit         mfirst   [NI];
    bit         macc     [NI];
    logic [1:0] hist     [NI][MAXC];
    int         pidx     [NI][6][6];

    logic [29:0] rec_op   [NI][RC];
    logic        rec_rdy  [NI][RC];
    logic        rec_busy [NI][RC];
    logic        rec_done [NI][RC];
    logic [7:0]  rec_ridx [NI][RC];

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s N=%0d cyc=%0d got=%0h want=%0h", nm, k + 1, cyc, got, want);
    endtask

    task automatic model_compare();
        for (int k = 0; k < NI; k++) begin
            logic [29:0] eo;
            int          e;
            eo = '0;
            if (!rst) begin
                rst_mark[k] = cyc;
                chk("op", k, 32'(op_w[k]), 32'(0));
                chk("in_ready", k, 32'(rdy_w[k]), 32'(0));
                chk("busy", k, 32'(busy_w[k]), 32'(0));
                chk("done", k, 32'(done_w[k]), 32'(0));
                chk("row_idx", k, 32'(ridx_w[k]), 32'(0));
            end else begin
                for (int i = 1; i <= k + 1; i++) begin
                    for (int j = i; j <= k + 1; j++) begin
                        e = cyc - (i + j - 2);
                        eo[2*pidx[k][i][j] +: 2] = (e < 0 || e <= rst_mark[k]) ? OP_HOLD : hist[k][e];
                    end
                end
                chk("op", k, 32'(op_w[k]), 32'(eo));
                chk("in_ready", k, 32'(rdy_w[k]), 32'(ph[k] == 1));
                chk("busy", k, 32'(busy_w[k]), 32'(ph[k] != 0));
                chk("done", k, 32'(done_w[k]), 32'(ph[k] == 2 && cyc == done_at[k]));
                chk("row_idx", k, 32'(ridx_w[k]), 32'(cnt[k]));
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            logic [1:0] c;
            c = OP_HOLD;
            if (!rst) begin
                ph[k]  = 0;
                cnt[k] = 0;
            end else begin
                case (ph[k])
                    0: if (start) begin
                        mrows[k]  = int'(cfg_rows);
                        macc[k]   = cfg_accum;
                        mfirst[k] = 1'b1;
                        cnt[k]    = 0;
                        if (cfg_rows == 8'd0) begin
                            ph[k] = 2;
                            done_at[k] = cyc + 2 * (k + 1) - 1;
                        end else begin
                            ph[k] = 1;
                        end
                    end
                    1: if (in_valid) begin
                        c = (mfirst[k] && !macc[k]) ? OP_INIT : OP_UPDATE;
                        mfirst[k] = 1'b0;
                        cnt[k]++;
                        if (cnt[k] == mrows[k]) begin
                            ph[k] = 2;
                            done_at[k] = cyc + 2 * (k + 1) - 1;
                        end
                    end
                    default: if (cyc == done_at[k] + 1) ph[k] = 0;
                endcase
            end
            hist[k][cyc] = c;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic cycle();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic record(input int c);
        for (int k = 0; k < NI; k++) begin
            rec_op[k][c]   = op_w[k];
            rec_rdy[k][c]  = rdy_w[k];
            rec_busy[k][c] = busy_w[k];
            rec_done[k][c] = done_w[k];
            rec_ridx[k][c] = ridx_w[k];
        end
    endtask

    // Frame with start in cycle 0; vpat gives in_valid per cycle (1 beyond bit 63).
    task automatic frame(input int rows, input bit acc, input logic [63:0] vpat,
                         input int ncyc, input int rst_at, input int s2_at);
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == s2_at);
            if (c == 0) begin
                cfg_rows  = 8'(rows);
                cfg_accum = acc;
            end
            if (c == s2_at) cfg_rows = 8'd1;
            in_valid = (c < 64) ? vpat[c] : 1'b1;
            rst = (c != rst_at);
            #1;
            record(c);
            cycle();
        end
        start = 1'b0; in_valid = 1'b0; rst = 1'b1;
    endtask

    task automatic idle(input int n);
        start = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < n; c++) cycle();
    endtask

    function automatic logic [1:0] fld(input int k, input int c, input int i, input int j);
        logic [29:0] v;
        v = rec_op[k][c];
        return v[2*pidx[k][i][j] +: 2];
    endfunction

    initial begin
        int ninit;
        for (int k = 0; k < NI; k++) begin
            int p;
            p = 0;
            ph[k] = 0; cnt[k] = 0; mrows[k] = 0; done_at[k] = 0; rst_mark[k] = -1;
            mfirst[k] = 1'b0; macc[k] = 1'b0;
            for (int i = 1; i <= k + 1; i++) begin
                for (int j = i; j <= k + 1; j++) begin
                    pidx[k][i][j] = p;
                    p++;
                end
            end
        end
        rst = 1'b1; start = 1'b0; cfg_rows = 8'd0; cfg_accum = 1'b0; in_valid = 1'b0;
        #1 rst = 1'b0;
        in_valid = 1'b1; start = 1'b1; cfg_rows = 8'd3;
        for (int c = 0; c < 3; c++) cycle();
        chk("reset_op", 3, 32'(op_w[3]), 32'(0));
        chk("reset_ready", 3, 32'(rdy_w[3]), 32'(0));
        chk("reset_busy", 3, 32'(busy_w[3]), 32'(0));
        rst = 1'b1;
        idle(2);

        for (int k = 0; k < NI; k++)
            for (int i = 1; i <= k + 1; i++)
                for (int j = i; j <= k + 1; j++)
                    chk("pe_index", k, 32'(pe_index(i, j, k + 1)), 32'(pidx[k][i][j]));

        // Basic frame: 3 rows, in_valid held high.
        frame(3, 1'b0, '1, 12, -1, -1);
        chk("b_ready", 1, 32'({rec_rdy[1][1], rec_rdy[1][2], rec_rdy[1][3], rec_rdy[1][4]}), 32'(4'b1110));
        chk("b_op11", 1, 32'({fld(1,2,1,1), fld(1,3,1,1), fld(1,4,1,1), fld(1,5,1,1)}), 32'(8'b01101000));
        chk("b_op12", 1, 32'({fld(1,3,1,2), fld(1,4,1,2), fld(1,5,1,2), fld(1,6,1,2)}), 32'(8'b01101000));
        chk("b_op22", 1, 32'({fld(1,4,2,2), fld(1,5,2,2), fld(1,6,2,2), fld(1,7,2,2)}), 32'(8'b01101000));
        chk("b_done", 1, 32'({rec_done[1][6], rec_done[1][7]}), 32'(2'b01));
        chk("b_busy", 1, 32'({rec_busy[1][7], rec_busy[1][8]}), 32'(2'b10));
        chk("b_done_n4", 3, 32'({rec_done[3][10], rec_done[3][11]}), 32'(2'b01));
        idle(4);

        // Bubbles: rows offered in cycles 1 and 4 only.
        frame(2, 1'b0, 64'b10010, 13, -1, -1);
        chk("bub_op33", 2, 32'({fld(2,6,3,3), fld(2,7,3,3), fld(2,8,3,3), fld(2,9,3,3)}), 32'(8'b01000010));
        chk("bub_done", 2, 32'({rec_done[2][9], rec_done[2][10]}), 32'(2'b01));
        chk("bub_row_idx", 2, 32'(rec_ridx[2][10]), 32'(2));
        idle(6);

        // Accumulate mode.
        frame(3, 1'b1, '1, 16, -1, -1);
        ninit = 0;
        for (int c = 0; c < 16; c++)
            for (int i = 1; i <= 5; i++)
                for (int j = i; j <= 5; j++)
                    if (fld(4, c, i, j) == OP_INIT) ninit++;
        chk("acc_no_init", 4, 32'(ninit), 32'(0));
        chk("acc_first11", 4, 32'(fld(4,2,1,1)), 32'(OP_UPDATE));
        chk("acc_first55", 4, 32'(fld(4,10,5,5)), 32'(OP_UPDATE));
        idle(2);

        // Zero rows.
        frame(0, 1'b0, '1, 13, -1, -1);
        for (int k = 0; k < NI; k++) begin
            int hi, nz;
            hi = 0; nz = 0;
            for (int c = 0; c < 13; c++) begin
                if (rec_rdy[k][c]) hi++;
                if (rec_op[k][c] != '0) nz++;
            end
            chk("zero_ready", k, 32'(hi), 32'(0));
            chk("zero_ops", k, 32'(nz), 32'(0));
            chk("zero_done", k, 32'({rec_done[k][2*k+1], rec_done[k][2*k+2]}), 32'(2'b01));
        end
        idle(2);

        // Start pulse (with cfg_rows=1) in the middle of RUN.
        frame(4, 1'b0, '1, 16, -1, 2);
        chk("sb_row_idx", 1, 32'(rec_ridx[1][8]), 32'(4));
        chk("sb_done", 1, 32'({rec_done[1][7], rec_done[1][8]}), 32'(2'b01));
        chk("sb_done_n5", 4, 32'(rec_done[4][14]), 32'(1));
        idle(2);

        // Reset while row 2 of 4 is in flight, then a clean frame.
        frame(4, 1'b0, '1, 6, 3, -1);
        chk("mr_before", 3, 32'(fld(3,2,1,1)), 32'(OP_INIT));
        chk("mr_op", 3, 32'(rec_op[3][3]), 32'(0));
        chk("mr_ready", 3, 32'(rec_rdy[3][3]), 32'(0));
        chk("mr_busy", 3, 32'(rec_busy[3][3]), 32'(0));
        frame(2, 1'b0, '1, 12, -1, -1);
        chk("mr_clean", 3, 32'({fld(3,2,1,1), fld(3,3,1,1)}), 32'(4'b0110));
        chk("mr_done", 3, 32'(rec_done[3][10]), 32'(1));
        idle(2);

        // Scaling: N=1 and N=5 with 5 rows.
        frame(5, 1'b0, '1, 18, -1, -1);
        chk("s1_op", 0, 32'({fld(0,2,1,1), fld(0,6,1,1), fld(0,7,1,1)}), 32'(6'b011000));
        chk("s1_done", 0, 32'({rec_done[0][6], rec_done[0][7]}), 32'(2'b01));
        chk("s5_op55", 4, 32'({fld(4,10,5,5), fld(4,14,5,5), fld(4,15,5,5)}), 32'(6'b011000));
        chk("s5_done", 4, 32'({rec_done[4][14], rec_done[4][15]}), 32'(2'b01));
        idle(2);

        // Largest row count must complete without wrap.
        frame(255, 1'b0, '1, 260, -1, -1);
        chk("max_done", 0, 32'({rec_done[0][256], rec_done[0][257]}), 32'(2'b01));
        chk("max_row_idx", 0, 32'(rec_ridx[0][257]), 32'(255));
        idle(12);

        // Random traffic with occasional resets and stray starts.
        for (int t = 0; t < 2500; t++) begin
            start     = ($urandom_range(0, 7) == 0);
            cfg_rows  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            cfg_accum = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
